// File: rtl/rvfi_retire_serializer.sv
// Multi-channel RVFI retirement to single-channel serializer.
// Compacts valid lanes into an in-order FIFO and tags each popped record with a sequence number.
module rvfi_retire_serializer #(
  parameter int unsigned NRET  = 2,
  parameter int unsigned REC_W = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NRET-1:0]           in_valid,
  input  logic [NRET*REC_W-1:0]     in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [REC_W-1:0]          out_data,
  input  logic                      out_ready,
  output logic [SEQ_W-1:0]          out_seq,
  input  logic [SEQ_W-1:0]          check_seq,
  output logic                      out_check,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  // Mask keeps a degenerate single-entry FIFO pinned to slot 0.
  localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

  logic [REC_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W-1:0] rd_ptr_next, wr_ptr_next;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] push_n;
  logic [SEQ_W-1:0] seq_next;
  logic             ovf_next;
  logic             any_valid, push, pop, drop;
  logic [PTR_W-1:0] lane_idx [NRET];

  // Flow control: readiness comes from registered occupancy only.
  assign in_ready  = (CNT_W'(DEPTH) - count) >= CNT_W'(NRET);
  assign out_valid = (count != '0);
  assign any_valid = |in_valid;
  assign push      = any_valid && in_ready;
  assign drop      = any_valid && !in_ready;
  assign pop       = out_valid && out_ready;

  // Head presentation; storage is never exposed while empty.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_check = out_valid && (out_seq == check_seq);

  // Lane compaction: each valid lane lands after all lower-indexed valid lanes.
  always_comb begin
    push_n = '0;
    for (int i = 0; i < NRET; i++) begin
      lane_idx[i] = (wr_ptr + PTR_W'(push_n)) & PTR_MASK;
      push_n      = push_n + CNT_W'(in_valid[i]);
    end
  end

  always_comb begin
    count_next  = count;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    seq_next    = out_seq;
    ovf_next    = overflow | drop;
    if (push) begin
      count_next  = count_next + push_n;
      wr_ptr_next = (wr_ptr + PTR_W'(push_n)) & PTR_MASK;
    end
    if (pop) begin
      count_next  = count_next - CNT_W'(1);
      rd_ptr_next = (rd_ptr + PTR_W'(1)) & PTR_MASK;
      seq_next    = out_seq + SEQ_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      out_seq  <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count_next;
      rd_ptr   <= rd_ptr_next;
      wr_ptr   <= wr_ptr_next;
      out_seq  <= seq_next;
      overflow <= ovf_next;
    end
  end

  // Record storage, intentionally not reset.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      for (int i = 0; i < NRET; i++) begin
        if (in_valid[i]) mem[lane_idx[i]] <= in_data[i*REC_W +: REC_W];
      end
    end
  end

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Scoreboard bench for rvfi_retire_serializer (NRET=2, REC_W=64, DEPTH=8, SEQ_W=16).
module tb_rvfi_retire_serializer;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    in_valid;
  logic [127:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [63:0]   out_data;
  logic          out_ready;
  logic [15:0]   out_seq;
  logic [15:0]   check_seq;
  logic          out_check;
  logic          overflow;
  logic [3:0]    count;

  int total = 0;
  int bad   = 0;

  logic [63:0] q[$];
  logic [15:0] m_seq = '0;
  bit          m_ovf = 1'b0;

  rvfi_retire_serializer #(.NRET(2), .REC_W(64), .DEPTH(8), .SEQ_W(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_seq(out_seq), .check_seq(check_seq),
    .out_check(out_check), .overflow(overflow), .count(count)
  );

  always #5 clock = ~clock;

  // Advance one clock; the reference queue absorbs pops then pushes using pre-edge occupancy.
  task automatic tick();
    int free;
    @(posedge clock);
    if (!reset) begin
      q.delete();
      m_seq = '0;
      m_ovf = 1'b0;
    end else begin
      free = 8 - q.size();
      if (out_ready && q.size() > 0) begin
        void'(q.pop_front());
        m_seq = m_seq + 16'd1;
      end
      if (in_valid != 2'b00) begin
        if (free >= 2) begin
          for (int i = 0; i < 2; i++)
            if (in_valid[i]) q.push_back(in_data[i*64 +: 64]);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 2'b11; in_data = '1; out_ready = 1'b0; check_seq = '0;
    tick(); tick();
    reset = 1'b1; in_valid = 2'b00;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== 64'd0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    total++; if (out_check !== 1'b0) begin bad++; $display("FAIL reset_out_check got=%0b exp=0", out_check); end
  endtask

  task automatic test_pair();
    logic [63:0] a, b;
    a = 64'hAAAA_0000_1111_000A;
    b = 64'hBBBB_0000_2222_000B;
    in_valid = 2'b11; in_data = {b, a}; out_ready = 1'b1;
    tick();
    in_valid = 2'b00;
    total++; if (out_valid !== 1'b1 || out_data !== a) begin bad++; $display("FAIL pair_first got=%0b/%0h exp=1/%0h", out_valid, out_data, a); end
    total++; if (out_seq !== 16'd0) begin bad++; $display("FAIL pair_seq0 got=%0d exp=0", out_seq); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== b) begin bad++; $display("FAIL pair_second got=%0b/%0h exp=1/%0h", out_valid, out_data, b); end
    total++; if (out_seq !== 16'd1) begin bad++; $display("FAIL pair_seq1 got=%0d exp=1", out_seq); end
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 64'd0) begin bad++; $display("FAIL pair_empty got=%0b/%0h exp=0/0", out_valid, out_data); end
  endtask

  task automatic test_sparse();
    logic [63:0] c;
    c = 64'hC0C0_C0C0_1234_5678;
    out_ready = 1'b0; in_valid = 2'b10; in_data = {c, 64'hDEAD_BEEF_DEAD_BEEF};
    tick();
    in_valid = 2'b00;
    total++; if (count !== 4'd1) begin bad++; $display("FAIL sparse_count got=%0d exp=1", count); end
    total++; if (out_data !== c) begin bad++; $display("FAIL sparse_head got=%0h exp=%0h", out_data, c); end
    total++; if (out_seq !== 16'd2) begin bad++; $display("FAIL sparse_seq got=%0d exp=2", out_seq); end
    out_ready = 1'b1;
    tick();
    total++; if (count !== 4'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL sparse_drain got=%0d/%0b exp=0/0", count, out_valid); end
  endtask

  task automatic test_fill_overflow();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 2'b11; in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 2'b00;
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_overflow got=%0b exp=0", overflow); end
    in_valid = 2'b11; in_data = {2{64'hFFFF_0000_FFFF_0000}};
    tick();
    in_valid = 2'b00;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drop_overflow got=%0b exp=1", overflow); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL drop_count got=%0d exp=8", count); end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL fill_valid got=%0b exp=%0b", out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        total++; if (out_data !== q[0]) begin bad++; $display("FAIL fill_data got=%0h exp=%0h", out_data, q[0]); end
        total++; if (out_seq !== m_seq) begin bad++; $display("FAIL fill_seq got=%0d exp=%0d", out_seq, m_seq); end
      end
      tick();
    end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL fill_drained got=%0d exp=0", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%0b exp=1", overflow); end
  endtask

  task automatic test_back_to_back();
    check_seq = 16'd20;
    for (int k = 0; k < 300; k++) begin
      total++; if (count !== 4'(q.size())) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", count, q.size()); end
      total++; if (in_ready !== (q.size() <= 6)) begin bad++; $display("FAIL b2b_in_ready got=%0b exp=%0b", in_ready, q.size() <= 6); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL b2b_overflow got=%0b exp=%0b", overflow, m_ovf); end
      total++; if (out_check !== (q.size() > 0 && m_seq == check_seq)) begin bad++; $display("FAIL b2b_check got=%0b", out_check); end
      if (q.size() > 0) begin
        total++; if (out_data !== q[0] || out_seq !== m_seq) begin bad++; $display("FAIL b2b_head got=%0h/%0d exp=%0h/%0d", out_data, out_seq, q[0], m_seq); end
      end else begin
        total++; if (out_data !== 64'd0) begin bad++; $display("FAIL b2b_empty_data got=%0h exp=0", out_data); end
      end
      in_valid  = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 2'b00;
  endtask

  task automatic test_check();
    logic [63:0] recs [8];
    int hits;
    hits = 0;
    reset = 1'b0; in_valid = 2'b00; out_ready = 1'b0;
    tick();
    reset = 1'b1; check_seq = 16'd5; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) recs[i] = {$urandom, $urandom};
    for (int c = 0; c < 20; c++) begin
      if (out_valid && q.size() > 0) begin
        total++; if (out_data !== q[0]) begin bad++; $display("FAIL chk_stream_data got=%0h exp=%0h", out_data, q[0]); end
      end
      if (out_check) begin
        hits++;
        total++; if (out_seq !== 16'd5 || out_data !== recs[5]) begin bad++; $display("FAIL chk_target got=%0d/%0h exp=5/%0h", out_seq, out_data, recs[5]); end
      end
      if (c < 4) begin
        in_valid = 2'b11; in_data = {recs[2*c+1], recs[2*c]};
      end else begin
        in_valid = 2'b00;
      end
      tick();
    end
    total++; if (hits != 1) begin bad++; $display("FAIL chk_hits got=%0d exp=1", hits); end
    total++; if (count !== 4'd0 || out_seq !== 16'd8) begin bad++; $display("FAIL chk_end got=%0d/%0d exp=0/8", count, out_seq); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 2'b11; in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 2'b00; out_ready = 1'b1;
    tick(); tick();
    total++; if (count !== 4'd6 || overflow !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%0b exp=6/1", count, overflow); end
    in_valid = 2'b11; in_data = {$urandom, $urandom, $urandom, $urandom}; reset = 1'b0;
    tick();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
    total++; if (out_seq !== 16'd0) begin bad++; $display("FAIL mid_seq got=%0d exp=0", out_seq); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%0b exp=0", overflow); end
    total++; if (out_valid !== 1'b0 || out_data !== 64'd0) begin bad++; $display("FAIL mid_valid got=%0b/%0h exp=0/0", out_valid, out_data); end
    tick();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_hold_ignored got=%0d exp=0", count); end
    reset = 1'b1; in_valid = 2'b00;
    tick();
    total++; if (count !== 4'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_release got=%0d/%0b exp=0/1", count, in_ready); end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_sparse();
    test_fill_overflow();
    test_back_to_back();
    test_check();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
